// File: rtl/spi_stream_tx.sv
// Frame transmitter: accepts bytes over valid/ready and shifts them out MSB-first
// with a generated serial clock, active-low chip select and a per-byte strobe.
module spi_stream_tx #(
    parameter int CLK_DIV     = 4,
    parameter int FRAME_BYTES = 100
) (
    input  logic       CLK_40_i,
    input  logic       reset_i,
    input  logic       start_req_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       SPI_clk_o,
    output logic       serial_data_o,
    output logic       chip_select_o,
    output logic       data_write_clk_o,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic       underrun_o
);

    localparam int BYTE_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(CLK_DIV - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(FRAME_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_TAIL
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              stall_q, stall_d;
    logic              spi_clk_q, spi_clk_d;
    logic              sdata_q, sdata_d;
    logic              cs_q, cs_d;
    logic              dwc_q, dwc_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              underrun_q, underrun_d;

    always_ff @(posedge CLK_40_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            div_q      <= '0;
            stall_q    <= 1'b0;
            spi_clk_q  <= 1'b0;
            sdata_q    <= 1'b0;
            cs_q       <= 1'b1;
            dwc_q      <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            div_q      <= div_d;
            stall_q    <= stall_d;
            spi_clk_q  <= spi_clk_d;
            sdata_q    <= sdata_d;
            cs_q       <= cs_d;
            dwc_q      <= dwc_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        div_d      = div_q;
        stall_d    = stall_q;
        spi_clk_d  = spi_clk_q;
        sdata_d    = sdata_q;
        cs_d       = cs_q;
        dwc_d      = dwc_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        underrun_d = underrun_q;

        case (state_q)
            S_IDLE: begin
                spi_clk_d = 1'b0;
                sdata_d   = 1'b0;
                cs_d      = 1'b1;
                dwc_d     = 1'b0;
                ready_d   = 1'b0;
                busy_d    = 1'b0;
                if (start_req_i) begin
                    state_d    = S_LOAD;
                    cs_d       = 1'b0;
                    busy_d     = 1'b1;
                    ready_d    = 1'b1;
                    byte_cnt_d = '0;
                    stall_d    = 1'b0;
                    underrun_d = 1'b0;
                end
            end

            S_LOAD: begin
                if (tx_valid_i) begin
                    shreg_d   = tx_data_i;
                    sdata_d   = tx_data_i[7];
                    bit_cnt_d = '0;
                    div_d     = DIV_LOAD;
                    ready_d   = 1'b0;
                    state_d   = S_SHIFT_LO;
                end else begin
                    // The first empty LOAD cycle is the normal inter-byte slot, not a stall.
                    if (stall_q) underrun_d = 1'b1;
                    stall_d = 1'b1;
                end
            end

            S_SHIFT_LO: begin
                if (div_q == '0) begin
                    spi_clk_d = 1'b1;
                    dwc_d     = (bit_cnt_q == 3'd7);
                    div_d     = DIV_LOAD;
                    state_d   = S_SHIFT_HI;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end

            S_SHIFT_HI: begin
                if (div_q == '0) begin
                    spi_clk_d = 1'b0;
                    dwc_d     = 1'b0;
                    if (bit_cnt_q != 3'd7) begin
                        shreg_d   = {shreg_q[6:0], 1'b0};
                        sdata_d   = shreg_q[6];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        div_d     = DIV_LOAD;
                        state_d   = S_SHIFT_LO;
                    end else if (byte_cnt_q == LAST_BYTE) begin
                        div_d   = DIV_LOAD;
                        state_d = S_TAIL;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        ready_d    = 1'b1;
                        stall_d    = 1'b0;
                        state_d    = S_LOAD;
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
            end

            S_TAIL: begin
                // The frame_done cycle is still spent in TAIL so a start in it is ignored.
                if (done_q) begin
                    state_d = S_IDLE;
                end else if (div_q == '0) begin
                    cs_d    = 1'b1;
                    busy_d  = 1'b0;
                    sdata_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign tx_ready_o       = ready_q;
    assign SPI_clk_o        = spi_clk_q;
    assign serial_data_o    = sdata_q;
    assign chip_select_o    = cs_q;
    assign data_write_clk_o = dwc_q;
    assign busy_o           = busy_q;
    assign frame_done_o     = done_q;
    assign underrun_o       = underrun_q;

endmodule

// File: tb/tb_spi_stream_tx.sv
// Directed bench for spi_stream_tx: three parameterisations share stimulus, a
// muxed monitor reassembles bytes and a queue scoreboard checks them.
module tb_spi_stream_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;

    logic a_ready, a_spi, a_sd, a_cs, a_dwc, a_busy, a_done, a_und;
    logic b_ready, b_spi, b_sd, b_cs, b_dwc, b_busy, b_done, b_und;
    logic c_ready, c_spi, c_sd, c_cs, c_dwc, c_busy, c_done, c_und;

    spi_stream_tx #(.CLK_DIV(4), .FRAME_BYTES(3)) u_a (
        .CLK_40_i(clk), .reset_i(reset), .start_req_i(start_a), .tx_data_i(tx_data),
        .tx_valid_i(tx_valid), .tx_ready_o(a_ready), .SPI_clk_o(a_spi),
        .serial_data_o(a_sd), .chip_select_o(a_cs), .data_write_clk_o(a_dwc),
        .busy_o(a_busy), .frame_done_o(a_done), .underrun_o(a_und));

    spi_stream_tx #(.CLK_DIV(4), .FRAME_BYTES(1)) u_b (
        .CLK_40_i(clk), .reset_i(reset), .start_req_i(start_b), .tx_data_i(tx_data),
        .tx_valid_i(tx_valid), .tx_ready_o(b_ready), .SPI_clk_o(b_spi),
        .serial_data_o(b_sd), .chip_select_o(b_cs), .data_write_clk_o(b_dwc),
        .busy_o(b_busy), .frame_done_o(b_done), .underrun_o(b_und));

    spi_stream_tx #(.CLK_DIV(8), .FRAME_BYTES(100)) u_c (
        .CLK_40_i(clk), .reset_i(reset), .start_req_i(start_c), .tx_data_i(tx_data),
        .tx_valid_i(tx_valid), .tx_ready_o(c_ready), .SPI_clk_o(c_spi),
        .serial_data_o(c_sd), .chip_select_o(c_cs), .data_write_clk_o(c_dwc),
        .busy_o(c_busy), .frame_done_o(c_done), .underrun_o(c_und));

    int   sel = 0;
    logic m_ready, m_spi, m_sd, m_cs, m_dwc, m_busy, m_done, m_und;

    always_comb begin
        {m_ready, m_spi, m_sd, m_cs, m_dwc, m_busy, m_done, m_und} = '0;
        case (sel)
            0: {m_ready, m_spi, m_sd, m_cs, m_dwc, m_busy, m_done, m_und} =
                   {a_ready, a_spi, a_sd, a_cs, a_dwc, a_busy, a_done, a_und};
            1: {m_ready, m_spi, m_sd, m_cs, m_dwc, m_busy, m_done, m_und} =
                   {b_ready, b_spi, b_sd, b_cs, b_dwc, b_busy, b_done, b_und};
            default: {m_ready, m_spi, m_sd, m_cs, m_dwc, m_busy, m_done, m_und} =
                   {c_ready, c_spi, c_sd, c_cs, c_dwc, c_busy, c_done, c_und};
        endcase
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor samples 2 time units after each rising edge; the initial block works on falling edges.
    logic        mon_clr = 1'b1;
    logic        spi_prev = 1'b0;
    logic [7:0]  rx_sh = 8'h00;
    int          nbit = 0, rises = 0, hs_cnt = 0, dwc_cnt = 0, dwc_bad = 0, done_cnt = 0;
    int unsigned done_cyc = 0;
    logic [7:0]  rx_q[$];
    int unsigned first_rise_q[$];

    always @(posedge clk) begin
        #2;
        if (mon_clr) begin
            spi_prev = 1'b0; rx_sh = 8'h00; nbit = 0; rises = 0; hs_cnt = 0;
            dwc_cnt = 0; dwc_bad = 0; done_cnt = 0; done_cyc = 0;
            rx_q.delete(); first_rise_q.delete();
        end else begin
            if (m_spi && !spi_prev) begin
                rises++;
                rx_sh = {rx_sh[6:0], m_sd};
                if (nbit == 0) first_rise_q.push_back(cyc);
                if ((nbit == 7) != m_dwc) dwc_bad++;
                if (nbit == 7) begin
                    rx_q.push_back(rx_sh);
                    nbit = 0;
                end else begin
                    nbit++;
                end
            end
            if (m_dwc) dwc_cnt++;
            if (m_ready && tx_valid) hs_cnt++;
            if (m_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            spi_prev = m_spi;
        end
    end

    int         n_tests = 0, n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pat[0:127];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        start_a = (sel == 0) && v;
        start_b = (sel == 1) && v;
        start_c = (sel == 2) && v;
    endtask

    task automatic check_scoreboard(input string tag);
        chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
        while (exp_q.size() > 0 && rx_q.size() > 0)
            chk({tag, "_byte"}, {24'h0, rx_q.pop_front()}, {24'h0, exp_q.pop_front()});
        exp_q.delete();
    endtask

    // Runs one frame of n bytes from pat[]; returns on the falling edge of the frame_done cycle.
    task automatic run_frame(input int n, input int gap_idx, input int gap_len,
                             input bit poke_hi, input bit poke_done,
                             output int unsigned t0, output bit gap_ok);
        int k;
        gap_ok = 1'b1;
        exp_q.delete();
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr  = 1'b0;
        tx_data  = pat[0];
        tx_valid = (gap_idx != 0);
        set_start(1'b1);
        t0 = cyc;
        @(negedge clk);
        set_start(1'b0);
        chk("cyc1_cs", m_cs, 0);
        chk("cyc1_ready", m_ready, 1);
        chk("cyc1_underrun_clear", m_und, 0);
        for (int i = 0; i < n; i++) begin
            if (i == gap_idx) begin
                tx_valid = 1'b0;
                for (k = 0; k < 3000 && !m_ready; k++) @(negedge clk);
                repeat (gap_len) begin
                    if (m_spi !== 1'b0 || m_cs !== 1'b0) gap_ok = 1'b0;
                    @(negedge clk);
                end
            end
            tx_data  = pat[i];
            tx_valid = 1'b1;
            for (k = 0; k < 3000 && !m_ready; k++) @(negedge clk);
            if (!m_ready) begin
                chk("handshake_timeout", m_ready, 1);
                return;
            end
            exp_q.push_back(pat[i]);
            @(negedge clk);
            if (i + 1 < n) tx_data = pat[i + 1];
            if (poke_hi && i == 0) begin
                for (k = 0; k < 100 && !m_spi; k++) @(negedge clk);
                set_start(1'b1);
                @(negedge clk);
                set_start(1'b0);
            end
        end
        for (k = 0; k < 3000 && !m_done; k++) @(negedge clk);
        chk("frame_done_seen", m_done, 1);
        if (poke_done) begin
            set_start(1'b1);
            @(negedge clk);
            set_start(1'b0);
        end
    endtask

    int unsigned t0;
    bit          gap_ok;

    initial begin
        // Reset values
        sel = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {24'h0, a_cs, a_spi, a_sd, a_dwc, a_ready, a_busy, a_done, a_und},
            32'h80);

        // Single byte, FRAME_BYTES=1, CLK_DIV=4
        sel = 1;
        pat[0] = 8'hA5;
        run_frame(1, -1, 0, 1'b0, 1'b0, t0, gap_ok);
        chk("single_cs_high_at_done", m_cs, 1);
        chk("single_busy_low_at_done", m_busy, 0);
        chk("single_done_cycle", done_cyc - t0, 70);
        chk("single_first_rise", first_rise_q[0] - t0, 6);
        chk("single_rises", rises, 8);
        chk("single_dwc_cycles", dwc_cnt, 4);
        chk("single_dwc_placement", dwc_bad, 0);
        check_scoreboard("single");
        @(negedge clk);
        chk("single_done_one_cycle", m_done, 0);

        // Back-to-back bytes, FRAME_BYTES=3
        sel = 0;
        pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h3C;
        run_frame(3, -1, 0, 1'b0, 1'b0, t0, gap_ok);
        chk("b2b_rises", rises, 24);
        chk("b2b_handshakes", hs_cnt, 3);
        chk("b2b_byte_period_0_1", first_rise_q[1] - first_rise_q[0], 65);
        chk("b2b_byte_period_1_2", first_rise_q[2] - first_rise_q[1], 65);
        chk("b2b_done_cycle", done_cyc - t0, 200);
        chk("b2b_dwc_placement", dwc_bad, 0);
        chk("b2b_no_underrun", m_und, 0);
        check_scoreboard("b2b");
        repeat (3) @(negedge clk);

        // Underrun: tx_valid withheld for 20 cycles before byte 2
        pat[0] = 8'h81; pat[1] = 8'h7E; pat[2] = 8'hC3;
        run_frame(3, 2, 20, 1'b0, 1'b0, t0, gap_ok);
        chk("underrun_gap_held", gap_ok, 1);
        chk("underrun_flag", m_und, 1);
        chk("underrun_rises", rises, 24);
        check_scoreboard("underrun");
        repeat (3) @(negedge clk);
        chk("underrun_sticky_idle", m_und, 1);

        // Ignored starts during SHIFT_HI and on the frame_done cycle; also clears underrun
        pat[0] = 8'h5A; pat[1] = 8'h96; pat[2] = 8'h0F;
        run_frame(3, -1, 0, 1'b1, 1'b1, t0, gap_ok);
        chk("ignored_done_cycle", done_cyc - t0, 200);
        chk("ignored_rises", rises, 24);
        check_scoreboard("ignored");
        @(negedge clk);
        chk("ignored_stays_idle_busy", m_busy, 0);
        chk("ignored_stays_idle_cs", m_cs, 1);
        chk("ignored_done_count", done_cnt, 1);

        // Reset after the 3rd bit of byte 0
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr  = 1'b0;
        tx_data  = 8'hE7;
        tx_valid = 1'b1;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        for (int k = 0; k < 200 && rises < 3; k++) @(negedge clk);
        chk("midreset_reached_bit3", rises, 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_outputs", {28'h0, m_cs, m_spi, m_busy, m_ready}, 32'h8);
        pat[0] = 8'h12; pat[1] = 8'h34; pat[2] = 8'h56;
        run_frame(3, -1, 0, 1'b0, 1'b0, t0, gap_ok);
        chk("midreset_refill_done_cycle", done_cyc - t0, 200);
        check_scoreboard("midreset");

        // 100-byte pattern, CLK_DIV=8
        sel = 2;
        for (int i = 0; i < 100; i++) pat[i] = 8'(i * 37 + 11);
        run_frame(100, -1, 0, 1'b0, 1'b0, t0, gap_ok);
        chk("long_rises", rises, 800);
        chk("long_done_cycle", done_cyc - t0, 12909);
        chk("long_dwc_placement", dwc_bad, 0);
        check_scoreboard("long");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_stream_tx.md
# spi_stream_tx

Serial stream transmitter that drives the far end of the playback link: it takes frame bytes over a valid/ready handshake and shifts them out MSB-first on `serial_data`, with a generated `SPI_clk`, active-low `chip_select` and a per-byte `data_write_clk` strobe. It is the source side of the serial interface the `DATA_FSM` receiver samples on `SPI_clk` rising edges. It serves as the stimulus/loopback source for the playback path and as the board-level driver when streaming from on-chip memory. One transaction sends exactly `FRAME_BYTES` bytes under a single `chip_select` assertion.

## Interface
- `CLK_DIV`, 4, `CLK_40` cycles per `SPI_clk` half-period; must be ≥1.
- `FRAME_BYTES`, 100, bytes per transaction; must be ≥1.

- `CLK_40` in 1 system clock; the block's only clock.
- `reset` in 1 synchronous, active-high reset.
- `start_req` in 1 single-cycle transaction start; honoured only in IDLE.
- `tx_data` in 8 byte to send; bit 7 is sent first.
- `tx_valid` in 1 `tx_data` is valid.
- `tx_ready` out 1 block accepts `tx_data` this cycle.
- `SPI_clk` out 1 serial clock; idles low.
- `serial_data` out 1 serial data; changes only while `SPI_clk` is low.
- `chip_select` out 1 active low for the whole transaction.
- `data_write_clk` out 1 byte strobe; high during the high phase of each byte's bit 0.
- `busy` out 1 transaction in progress.
- `frame_done` out 1 one-cycle pulse at the end of the transaction.
- `underrun` out 1 sticky flag: the block stalled waiting for `tx_valid`. Cleared by an accepted `start_req`.

## Operation
- All outputs are registered. Reset values:
  - `SPI_clk`=0, `serial_data`=0, `chip_select`=1.
  - `data_write_clk`=0, `tx_ready`=0, `busy`=0.
  - `frame_done`=0, `underrun`=0.
- State machine IDLE → LOAD → SHIFT_LO → SHIFT_HI → (SHIFT_LO | LOAD | TAIL) → IDLE.
- **IDLE**
  - Outputs hold their reset values, except `underrun`, which holds its value.
  - On `start_req`: go to LOAD with `chip_select`=0, `busy`=1, `byte_cnt`=0, `underrun`=0.
- **LOAD**
  - `tx_ready`=1 and `SPI_clk`=0.
  - On `tx_valid`: latch `tx_data` into the shift register, set `serial_data`=`tx_data[7]`, `bit_cnt`=0, then go to SHIFT_LO.
  - Each LOAD cycle beyond the first with `tx_valid`=0 sets `underrun`. `chip_select` stays low and `SPI_clk` stays low (clock stretch).
- **SHIFT_LO**: `SPI_clk`=0 for `CLK_DIV` cycles, then `SPI_clk` rises and the state moves to SHIFT_HI.
- **SHIFT_HI**
  - `SPI_clk`=1 for `CLK_DIV` cycles.
  - `data_write_clk`=1 throughout this phase when `bit_cnt`=7.
  - At the end of the phase `SPI_clk` falls, then:
    - `bit_cnt`<7: shift, put the next bit on `serial_data`, increment `bit_cnt`, go to SHIFT_LO.
    - `bit_cnt`=7 and `byte_cnt`=`FRAME_BYTES`-1: go to TAIL.
    - `bit_cnt`=7 otherwise: increment `byte_cnt` and go to LOAD.
- **TAIL**: `chip_select` stays low for `CLK_DIV` cycles. Then `chip_select`=1, `busy`=0, `serial_data`=0, `frame_done`=1 for one cycle, and the state returns to IDLE.
- Widths:
  - `bit_cnt` is 3 bits.
  - `byte_cnt` is $clog2(`FRAME_BYTES`) bits (minimum 1); it never wraps within a transaction.
  - The divider counter is $clog2(`CLK_DIV`) bits (minimum 1).
- Boundary conditions:
  - `start_req` outside IDLE is ignored.
  - `start_req` in the same cycle as `frame_done` is ignored; the block is still in TAIL.
  - `tx_valid` is ignored outside LOAD.
  - `reset` mid-transaction: on the next edge all outputs take their reset values and the partial byte is discarded.
  - `FRAME_BYTES`=1: LOAD happens once, then TAIL.

## Timing
- The handshake completes in a LOAD cycle with `tx_valid`=1; `tx_ready` drops on the next edge.
- With `tx_valid` held high and `start_req` at cycle 0:
  - Cycle 1: `chip_select`=0 and `tx_ready`=1; handshake.
  - Cycle 2: `serial_data`=bit 7.
  - `SPI_clk` first rises at cycle 2+`CLK_DIV`.
- Bit period is 2·`CLK_DIV` cycles. Each bit is stable from `CLK_DIV` cycles before its rising edge until the falling edge.
- Byte period with no stall is 16·`CLK_DIV`+1 cycles. The extra cycle is the LOAD cycle, which lengthens the inter-byte low phase to `CLK_DIV`+1.
- With no stall, `frame_done` is asserted at cycle 1+`FRAME_BYTES`·(16·`CLK_DIV`+1)+`CLK_DIV`.
- `data_write_clk` rises in the same cycle as the 8th `SPI_clk` rising edge of each byte and falls with it.

## Test plan
- **Single byte**: `FRAME_BYTES`=1, `CLK_DIV`=4, `tx_data`=0xA5, `start_req` at cycle 0.
  - `serial_data` sampled on the 8 `SPI_clk` rises reads 1,0,1,0,0,1,0,1.
  - `data_write_clk` is high for 4 cycles on the last rise.
  - `frame_done` at cycle 70; `chip_select` high from cycle 70.
- **Back-to-back bytes**: `FRAME_BYTES`=3, bytes 0x00, 0xFF, 0x3C, `tx_valid` always high.
  - Exactly 24 `SPI_clk` rises and 3 handshakes.
  - The bytes reassemble correctly.
  - Rising edges of `SPI_clk` are 65 cycles apart at byte boundaries.
- **Underrun**: drop `tx_valid` for 20 cycles before byte 2.
  - `SPI_clk` stays low and `chip_select` stays low during the gap.
  - `underrun`=1 afterwards; data is still correct.
  - The next `start_req` clears `underrun`.
- **Ignored start**: pulse `start_req` during SHIFT_HI and again on the `frame_done` cycle. Neither restarts the transaction or changes the output sequence.
- **Reset mid-byte**: assert `reset` after the 3rd bit of byte 0. On the next edge `chip_select`=1, `SPI_clk`=0, `busy`=0 and `tx_ready`=0; a new `start_req` sends a full frame.
- **Loopback**: feed `SPI_clk`, `serial_data` and `data_write_clk` into `DATA_FSM` through the `dff_sync2` synchronisers with `CLK_DIV`=8. `received_bit` reproduces a 100-byte pattern.
